piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_shreg.sv | 36 +++
 rtl/piso_tx.sv | 84 ++++++++
 tb/tb_piso_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter.
// Holds the FSM state encoding and the default word width.
package piso_pkg;

  localparam int PISO_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register with zero-fill and async active-high reset.
// The serial bit is taken from whichever end MSB_FIRST selects.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sbit
);

  logic [WIDTH-1:0] sreg_q;

  // Load wins over shift; the vacated end always fills with zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
    end else if (load_en) begin
      sreg_q <= din;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      end else begin
        sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
      end
    end
  end

  assign sbit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready
// handshake and shifts it out one bit per cycle, framed by sof and done.
//
// state | meaning
// IDLE  | waiting for a word, load_ready high
// SHIFT | driving one payload bit per cycle, load_ready low
// DONE  | one-cycle done pulse, may accept the next word
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             done
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  piso_state_e      state_q;
  piso_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_en_q;
  logic             accept;
  logic             in_shift;
  logic             sbit;

  // ready_en_q keeps load_ready low during reset and until the first edge after it
  assign in_shift   = (state_q == SHIFT);
  assign load_ready = ready_en_q && !in_shift;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = accept ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        cnt_q <= '0;
      end else if (in_shift) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  piso_shreg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (accept),
    .shift_en (in_shift),
    .din      (din),
    .sbit     (sbit)
  );

  assign sout_valid = in_shift;
  assign sout       = in_shift & sbit;
  assign sof        = in_shift && (cnt_q == '0);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: an MSB-first and an LSB-first instance share stimulus and
// are checked every cycle against a per-cycle expectation queue built on acceptance.
module tb_piso_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] din = '0;

  logic m_ready, m_sout, m_valid, m_sof, m_done;
  logic l_ready, l_sout, l_valid, l_sof, l_done;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(m_ready), .sout(m_sout), .sout_valid(m_valid),
    .sof(m_sof), .done(m_done)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(l_ready), .sout(l_sout), .sout_valid(l_valid),
    .sof(l_sof), .done(l_done)
  );

  typedef struct packed {
    logic sout;
    logic valid;
    logic sof;
    logic done;
  } exp_t;

  exp_t         qm[$];
  exp_t         ql[$];
  bit           armed = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  logic [W-1:0] acc_m = '0;
  logic [W-1:0] acc_l = '0;
  logic [W-1:0] got_m[$];
  logic [W-1:0] got_l[$];
  int           sof_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit model_ready();
    return armed && !rst && (qm.size() == 0 || qm[0].done);
  endfunction

  // One accepted word = W payload cycles followed by a single done cycle
  function automatic void push_word(input logic [W-1:0] word);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e = '{sout: word[W-1-i], valid: 1'b1, sof: (i == 0), done: 1'b0};
      qm.push_back(e);
      e.sout = word[i];
      ql.push_back(e);
    end
    e = '{sout: 1'b0, valid: 1'b0, sof: 1'b0, done: 1'b1};
    qm.push_back(e);
    ql.push_back(e);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit a;
    if (rst) begin
      qm.delete();
      ql.delete();
      armed = 1'b0;
    end else begin
      a = load_valid && model_ready();
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (a) push_word(din);
      armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t em;
    exp_t el;
    logic er;
    cyc++;
    em = (qm.size() > 0) ? qm[0] : exp_t'(0);
    el = (ql.size() > 0) ? ql[0] : exp_t'(0);
    er = model_ready();
    check("m_load_ready", m_ready, er);
    check("m_sout",       m_sout,  em.sout);
    check("m_sout_valid", m_valid, em.valid);
    check("m_sof",        m_sof,   em.sof);
    check("m_done",       m_done,  em.done);
    check("l_load_ready", l_ready, er);
    check("l_sout",       l_sout,  el.sout);
    check("l_sout_valid", l_valid, el.valid);
    check("l_sof",        l_sof,   el.sof);
    check("l_done",       l_done,  el.done);
    if (rst) begin
      acc_m = '0;
      acc_l = '0;
    end else begin
      if (m_valid) acc_m = {acc_m[W-2:0], m_sout};
      if (l_valid) acc_l = {acc_l[W-2:0], l_sout};
      if (m_sof) sof_cyc.push_back(cyc);
      if (m_done) begin
        got_m.push_back(acc_m);
        got_l.push_back(acc_l);
        done_cnt++;
      end
    end
  end

  task automatic wait_words(input int n);
    for (int i = 0; i < 40; i++) begin
      if (got_m.size() >= n) break;
      @(posedge clk);
    end
    check("wait_words", got_m.size(), n);
  endtask

  task automatic send_one(input logic [W-1:0] word);
    @(posedge clk);
    #2 din = word;
    load_valid = 1'b1;
    @(posedge clk);
    #2 load_valid = 1'b0;
    #4;
    check("first_bit_sof", m_sof, 1'b1);
    check("first_bit_m",   m_sout, word[W-1]);
    check("first_bit_l",   l_sout, word[0]);
  endtask

  initial begin
    int n;
    int d0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_load_ready", m_ready, 1'b0);
    check("rst_sout_valid", m_valid, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    check("idle_load_ready", m_ready, 1'b1);
    check("idle_sout", m_sout, 1'b0);

    n = got_m.size();
    send_one(8'hA5);
    wait_words(n + 1);
    check("word_a5_m", got_m[got_m.size()-1], 8'hA5);
    check("word_a5_l", got_l[got_l.size()-1], 8'hA5);

    n = got_m.size();
    send_one(8'h01);
    wait_words(n + 1);
    check("word_01_m", got_m[got_m.size()-1], 8'h01);
    check("word_01_l", got_l[got_l.size()-1], 8'h80);

    n = got_m.size();
    @(posedge clk);
    #2 din = 8'hFF;
    load_valid = 1'b1;
    @(posedge clk);
    #2 din = 8'h00;
    wait_words(n + 1);
    #2 load_valid = 1'b0;
    wait_words(n + 2);
    check("b2b_first",  got_m[n], 8'hFF);
    check("b2b_second", got_m[n+1], 8'h00);
    check("b2b_sof_spacing", sof_cyc[sof_cyc.size()-1] - sof_cyc[sof_cyc.size()-2], W + 1);

    n = got_m.size();
    @(posedge clk);
    #2 din = 8'hC3;
    load_valid = 1'b1;
    @(posedge clk);
    #2 din = 8'h3C;
    load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 load_valid = 1'b1;
    @(posedge clk);
    #2 load_valid = 1'b0;
    wait_words(n + 1);
    check("ignore_c3_m", got_m[got_m.size()-1], 8'hC3);
    check("ignore_c3_l", got_l[got_l.size()-1], 8'hC3);
    repeat (3) @(posedge clk);
    check("ignore_no_extra", got_m.size(), n + 1);

    @(posedge clk);
    #2 din = 8'hAA;
    load_valid = 1'b1;
    @(posedge clk);
    #2 load_valid = 1'b0;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #2;
    check("abort_mid_word", m_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_sout",       m_sout,  1'b0);
    check("abort_sout_valid", m_valid, 1'b0);
    check("abort_sof",        m_sof,   1'b0);
    check("abort_done",       m_done,  1'b0);
    check("abort_ready",      m_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("abort_no_done", done_cnt, d0);
    n = got_m.size();
    send_one(8'h81);
    wait_words(n + 1);
    check("after_rst_81_m", got_m[got_m.size()-1], 8'h81);
    check("after_rst_81_l", got_l[got_l.size()-1], 8'h81);
    check("after_rst_done_cnt", done_cnt, d0 + 1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
